rv32_dec_pipe: RTL

RV32_DEC_PIPE -- requirements
Module: rv32_dec_pipe

---
 rtl/rv32_dec_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32_dec_pipe.sv
// rv32_dec_pipe: RV32I decoder feeding a DEPTH-entry, per-hart flushable buffer.
// Define RV32_DEC_CSR_EN to also decode the six Zicsr instructions.
module rv32_dec_pipe #(
   parameter int NUM_HARTS = 8,
   parameter int DEPTH     = 2,
   localparam int HART_W   = $clog2(NUM_HARTS),
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [31:0]          in_pc,
   input  logic [HART_W-1:0]    in_hart,
   input  logic [NUM_HARTS-1:0] flush_mask,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [5:0]           out_opcode,
   output logic [5:0]           out_type,
   output logic [31:0]          out_imm,
   output logic [11:0]          out_csr,
   output logic [4:0]           out_rs1,
   output logic [4:0]           out_rs2,
   output logic [4:0]           out_rd,
   output logic [31:0]          out_pc,
   output logic [HART_W-1:0]    out_hart,
   output logic                 out_illegal,
   output logic [CNT_W-1:0]     occupancy
);

   localparam logic [5:0] OP_LB    = 6'h00, OP_LH    = 6'h01, OP_LW    = 6'h02;
   localparam logic [5:0] OP_LBU   = 6'h03, OP_LHU   = 6'h04, OP_SB    = 6'h05;
   localparam logic [5:0] OP_SH    = 6'h06, OP_SW    = 6'h07, OP_SLL   = 6'h08;
   localparam logic [5:0] OP_SLLI  = 6'h09, OP_SRL   = 6'h0A, OP_SRLI  = 6'h0B;
   localparam logic [5:0] OP_SRA   = 6'h0C, OP_SRAI  = 6'h0D, OP_ADD   = 6'h0E;
   localparam logic [5:0] OP_ADDI  = 6'h0F, OP_SUB   = 6'h10, OP_LUI   = 6'h11;
   localparam logic [5:0] OP_AUIPC = 6'h12, OP_XOR   = 6'h13, OP_XORI  = 6'h14;
   localparam logic [5:0] OP_OR    = 6'h15, OP_ORI   = 6'h16, OP_AND   = 6'h17;
   localparam logic [5:0] OP_ANDI  = 6'h18, OP_SLT   = 6'h19, OP_SLTI  = 6'h1A;
   localparam logic [5:0] OP_SLTU  = 6'h1B, OP_SLTIU = 6'h1C, OP_BEQ   = 6'h1D;
   localparam logic [5:0] OP_BNE   = 6'h1E, OP_BLT   = 6'h1F, OP_BGE   = 6'h20;
   localparam logic [5:0] OP_BLTU  = 6'h21, OP_BGEU  = 6'h22, OP_JAL   = 6'h23;
   localparam logic [5:0] OP_JALR  = 6'h24, OP_FENCE = 6'h25, OP_FENCI = 6'h26;
   localparam logic [5:0] OP_CSRRW = 6'h27, OP_CSRRS = 6'h28, OP_CSRRC = 6'h29;
   localparam logic [5:0] OP_CSRWI = 6'h2A, OP_CSRSI = 6'h2B, OP_CSRCI = 6'h2C;
   localparam logic [5:0] OP_ECALL = 6'h2D, OP_EBRK  = 6'h2E, OP_SRET  = 6'h2F;
   localparam logic [5:0] OP_MRET  = 6'h30, OP_WFI   = 6'h31, OP_NOP   = 6'h32;
   localparam logic [5:0] OP_UNK   = 6'h3F;

   localparam logic [5:0] T_R = 6'b100000, T_I = 6'b010000, T_S = 6'b001000;
   localparam logic [5:0] T_B = 6'b000100, T_U = 6'b000010, T_J = 6'b000001;
   localparam logic [5:0] T_NOP = 6'b000000, T_UNK = 6'b111111;

   typedef enum logic [3:0] {
      F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_SYS, F_CSR, F_NOP, F_UNK
   } fmt_e;

   typedef struct packed {
      logic [5:0]        opcode;
      logic [5:0]        typ;
      logic [31:0]       imm;
      logic [11:0]       csr;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [4:0]        rd;
      logic              illegal;
      logic [31:0]       pc;
      logic [HART_W-1:0] hart;
   } entry_t;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [5:0]  op;
   fmt_e        fmt;
   entry_t      dec;

   assign opc   = in_instr[6:0];
   assign f3    = in_instr[14:12];
   assign f7    = in_instr[31:25];
   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};

   always_comb begin
      op  = OP_UNK;
      fmt = F_UNK;
      unique case (opc)
         7'b0000011: begin
            fmt = F_I;
            unique case (f3)
               3'b000:  op = OP_LB;
               3'b001:  op = OP_LH;
               3'b010:  op = OP_LW;
               3'b100:  op = OP_LBU;
               3'b101:  op = OP_LHU;
               default: fmt = F_UNK;
            endcase
         end
         7'b0100011: begin
            fmt = F_S;
            unique case (f3)
               3'b000:  op = OP_SB;
               3'b001:  op = OP_SH;
               3'b010:  op = OP_SW;
               default: fmt = F_UNK;
            endcase
         end
         7'b0010011: begin
            fmt = F_I;
            unique case (f3)
               3'b000: op = OP_ADDI;
               3'b010: op = OP_SLTI;
               3'b011: op = OP_SLTIU;
               3'b100: op = OP_XORI;
               3'b110: op = OP_ORI;
               3'b111: op = OP_ANDI;
               3'b001: begin
                  fmt = (f7 == 7'h00) ? F_SH : F_UNK;
                  op  = (f7 == 7'h00) ? OP_SLLI : OP_UNK;
               end
               3'b101: begin
                  fmt = F_SH;
                  if (f7 == 7'h00)      op = OP_SRLI;
                  else if (f7 == 7'h20) op = OP_SRAI;
                  else                  fmt = F_UNK;
               end
            endcase
            // The canonical NOP is reported on its own, not as ADDI.
            if (in_instr == 32'h0000_0013) begin
               op  = OP_NOP;
               fmt = F_NOP;
            end
         end
         7'b0110011: begin
            fmt = F_R;
            if (f7 == 7'h00) begin
               unique case (f3)
                  3'b000: op = OP_ADD;
                  3'b001: op = OP_SLL;
                  3'b010: op = OP_SLT;
                  3'b011: op = OP_SLTU;
                  3'b100: op = OP_XOR;
                  3'b101: op = OP_SRL;
                  3'b110: op = OP_OR;
                  3'b111: op = OP_AND;
               endcase
            end else if (f7 == 7'h20 && f3 == 3'b000) begin
               op = OP_SUB;
            end else if (f7 == 7'h20 && f3 == 3'b101) begin
               op = OP_SRA;
            end else begin
               fmt = F_UNK;
            end
         end
         7'b0110111: begin op = OP_LUI;   fmt = F_U; end
         7'b0010111: begin op = OP_AUIPC; fmt = F_U; end
         7'b1101111: begin op = OP_JAL;   fmt = F_J; end
         7'b1100111: begin
            if (f3 == 3'b000) begin op = OP_JALR; fmt = F_I; end
         end
         7'b1100011: begin
            fmt = F_B;
            unique case (f3)
               3'b000:  op = OP_BEQ;
               3'b001:  op = OP_BNE;
               3'b100:  op = OP_BLT;
               3'b101:  op = OP_BGE;
               3'b110:  op = OP_BLTU;
               3'b111:  op = OP_BGEU;
               default: fmt = F_UNK;
            endcase
         end
         7'b0001111: begin
            fmt = F_I;
            if (f3 == 3'b000)      op = OP_FENCE;
            else if (f3 == 3'b001) op = OP_FENCI;
            else                   fmt = F_UNK;
         end
         7'b1110011: begin
            fmt = F_SYS;
            unique case (in_instr)
               32'h0000_0073: op = OP_ECALL;
               32'h0010_0073: op = OP_EBRK;
               32'h1020_0073: op = OP_SRET;
               32'h3020_0073: op = OP_MRET;
               32'h1050_0073: op = OP_WFI;
               default:       fmt = F_UNK;
            endcase
`ifdef RV32_DEC_CSR_EN
            if (f3 != 3'b000 && f3 != 3'b100) begin
               fmt = F_CSR;
               unique case (f3)
                  3'b001:  op = OP_CSRRW;
                  3'b010:  op = OP_CSRRS;
                  3'b011:  op = OP_CSRRC;
                  3'b101:  op = OP_CSRWI;
                  3'b110:  op = OP_CSRSI;
                  default: op = OP_CSRCI;
               endcase
            end
`endif
         end
         default: ;
      endcase
      if (fmt == F_UNK) op = OP_UNK;
   end

   always_comb begin
      dec        = '0;
      dec.opcode = op;
      unique case (fmt)
         F_R: begin
            dec.typ = T_R;
            dec.rd  = in_instr[11:7];
            dec.rs1 = in_instr[19:15];
            dec.rs2 = in_instr[24:20];
         end
         F_I: begin
            dec.typ = T_I;
            dec.rd  = in_instr[11:7];
            dec.rs1 = in_instr[19:15];
            dec.imm = imm_i;
         end
         F_SH: begin
            dec.typ = T_I;
            dec.rd  = in_instr[11:7];
            dec.rs1 = in_instr[19:15];
            dec.imm = {27'b0, in_instr[24:20]};
         end
         F_S: begin
            dec.typ = T_S;
            dec.rs1 = in_instr[19:15];
            dec.rs2 = in_instr[24:20];
            dec.imm = imm_s;
         end
         F_B: begin
            dec.typ = T_B;
            dec.rs1 = in_instr[19:15];
            dec.rs2 = in_instr[24:20];
            dec.imm = imm_b;
         end
         F_U: begin
            dec.typ = T_U;
            dec.rd  = in_instr[11:7];
            dec.imm = imm_u;
         end
         F_J: begin
            dec.typ = T_J;
            dec.rd  = in_instr[11:7];
            dec.imm = imm_j;
         end
         F_SYS: dec.typ = T_I;
         F_CSR: begin
            dec.typ = T_I;
            dec.rd  = in_instr[11:7];
            dec.rs1 = in_instr[19:15];
            dec.csr = in_instr[31:20];
         end
         F_NOP: dec.typ = T_NOP;
         default: begin
            dec.typ     = T_UNK;
            dec.illegal = 1'b1;
         end
      endcase
      dec.pc   = in_pc;
      dec.hart = in_hart;
   end

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   entry_t           sh    [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push, pop;
   int               pos, n_sh;

   assign in_ready  = (cnt_q < CNT_W'(DEPTH));
   assign out_valid = (cnt_q != '0);
   assign pop       = out_valid && out_ready;
   assign push      = in_valid && in_ready && !flush_mask[in_hart];

   // Pop first, then squeeze out flushed harts, then append the new entry.
   always_comb begin
      sh[DEPTH-1] = pop ? '0 : mem_q[DEPTH-1];
      for (int i = 0; i < DEPTH - 1; i++)
         sh[i] = pop ? mem_q[i+1] : mem_q[i];
      for (int j = 0; j < DEPTH; j++)
         mem_d[j] = '0;
      n_sh = int'(cnt_q) - int'(pop);
      pos  = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < n_sh && !flush_mask[sh[i].hart]) begin
            for (int j = 0; j < DEPTH; j++)
               if (j == pos) mem_d[j] = sh[i];
            pos = pos + 1;
         end
      end
      for (int j = 0; j < DEPTH; j++)
         if (push && j == pos) mem_d[j] = dec;
      cnt_d = CNT_W'(pos + int'(push));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
         mem_q <= mem_d;
      end
   end

   assign out_opcode  = mem_q[0].opcode;
   assign out_type    = mem_q[0].typ;
   assign out_imm     = mem_q[0].imm;
   assign out_csr     = mem_q[0].csr;
   assign out_rs1     = mem_q[0].rs1;
   assign out_rs2     = mem_q[0].rs2;
   assign out_rd      = mem_q[0].rd;
   assign out_pc      = mem_q[0].pc;
   assign out_hart    = mem_q[0].hart;
   assign out_illegal = mem_q[0].illegal;
   assign occupancy   = cnt_q;

endmodule
